// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory controller.
// Size encodings, FSM states and the registered response bundle.
package dmem_pkg;

  localparam logic [31:0] MARS_DATA_BASE = 32'h1001_0000;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

endpackage

// File: rtl/dmem_if.sv
// CPU-to-data-memory request/response bus.
// master drives requests, slave (the controller) drives ready and the response.
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: store byte enables/replication, load extraction/extension, alignment check.
// Purely combinational (0 cycles); no flow control of its own.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] st_dat,
  input  logic [31:0] ld_raw_dat,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_dat,
  output logic [31:0] ld_dat,
  output logic        misaligned,
  output logic        bad_size
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wr_be      = 4'b0000;
    wr_dat     = '0;
    ld_dat     = '0;
    misaligned = 1'b0;
    bad_size   = 1'b0;
    ld_byte    = ld_raw_dat[{lane, 3'b000} +: 8];
    ld_half    = lane[1] ? ld_raw_dat[31:16] : ld_raw_dat[15:0];
    case (size)
      SZ_BYTE: begin
        wr_be  = 4'b0001 << lane;
        wr_dat = {4{st_dat[7:0]}};
        ld_dat = {{24{sgn & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        misaligned = lane[0];
        wr_be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_dat     = {2{st_dat[15:0]}};
        ld_dat     = {{16{sgn & ld_half[15]}}, ld_half};
      end
      SZ_WORD: begin
        misaligned = |lane;
        wr_be      = 4'b1111;
        wr_dat     = st_dat;
        ld_dat     = ld_raw_dat;
      end
      default: bad_size = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: base decode, sized loads/stores, READ_LAT emulation; DMEM_ERR_LOG_EN adds error log.
// Store/error respond 1 cycle after accept, loads READ_LAT cycles; req_ready low until response done.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MARS_DATA_BASE,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus
`ifdef DMEM_ERR_LOG_EN
  ,
  output logic        err_sticky,
  output logic [31:0] err_addr
`endif
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [2:0]  WAIT_LAST = 3'(READ_LAT - 2);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  rsp_t        rsp_q, rsp_nx;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        oor, misaligned, bad_size, err, accept;
  logic [3:0]  wr_be;
  logic [31:0] wr_dat, ld_dat;

  // Offset wraps modulo 2^32, so addresses below the base land out of range.
  assign off    = bus.req_addr - BASE_ADDR;
  assign oor    = off >= SPAN;
  assign idx    = off[AW+1:2];
  assign err    = oor | misaligned | bad_size;
  assign accept = bus.req_valid & bus.req_ready & ~rst;

  dmem_lane_fmt u_fmt (
    .size       (bus.req_size),
    .lane       (bus.req_addr[1:0]),
    .sgn        (bus.req_signed),
    .st_dat     (bus.req_wdata),
    .ld_raw_dat (mem[idx]),
    .wr_be      (wr_be),
    .wr_dat     (wr_dat),
    .ld_dat     (ld_dat),
    .misaligned (misaligned),
    .bad_size   (bad_size)
  );

  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  always_comb begin
    rsp_nx.err   = err;
    rsp_nx.rdata = (err || bus.req_we) ? 32'd0 : ld_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) rsp_q <= rsp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_we || err || READ_LAT == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = '0;
          end
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) state_nx = RESP;
        else                  cnt_nx   = cnt + 3'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) & rsp_q.err;
  assign bus.rsp_rdata = (state == RESP) ? rsp_q.rdata : 32'd0;

`ifdef DMEM_ERR_LOG_EN
  // Only the first error since reset is recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (accept && err && !err_sticky) begin
      err_sticky <= 1'b1;
      err_addr   <= bus.req_addr;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench: three controllers (READ_LAT 1/3/4) against a word-array reference model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int          NI   = 3;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          NW   = 16;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst, vld, we, sgn, rdy, rsp_vld, rsp_err;
  logic [1:0]    size [NI];
  logic [31:0]   addr [NI];
  logic [31:0]   wdat [NI];
  logic [31:0]   rsp_dat [NI];
`ifdef DMEM_ERR_LOG_EN
  logic [NI-1:0] sticky;
  logic [31:0]   eaddr [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_if bus ();
    assign bus.req_valid  = vld[g];
    assign bus.req_we     = we[g];
    assign bus.req_size   = size[g];
    assign bus.req_signed = sgn[g];
    assign bus.req_addr   = addr[g];
    assign bus.req_wdata  = wdat[g];
    assign rdy[g]         = bus.req_ready;
    assign rsp_vld[g]     = bus.rsp_valid;
    assign rsp_err[g]     = bus.rsp_err;
    assign rsp_dat[g]     = bus.rsp_rdata;

    dmem_ctrl #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (1024),
      .READ_LAT    (lat_of(g))
    ) u_dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (bus)
`ifdef DMEM_ERR_LOG_EN
      ,
      .err_sticky (sticky[g]),
      .err_addr   (eaddr[g])
`endif
    );
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mdl [NI][NW];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: expected error, data and latency from the addressing/lane rules.
  task automatic txn(input int d, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] off, word, v, exp_d;
    logic        exp_e;
    int          k, n, exp_lat;
    off   = a - BASE;
    exp_e = (sz == 2'b11) || (sz == SZ_HALF && (a % 2) != 0) ||
            (sz == SZ_WORD && (a % 4) != 0) || (off >= 32'd4096);
    exp_d = 32'd0;
    if (!exp_e) begin
      word = mdl[d][off / 4];
      k    = 8 * int'(a % 4);
      if (w) begin
        if (sz == SZ_BYTE)      word = (word & ~(32'hFF << k))   | ((wd & 32'hFF) << k);
        else if (sz == SZ_HALF) word = (word & ~(32'hFFFF << k)) | ((wd & 32'hFFFF) << k);
        else                    word = wd;
        mdl[d][off / 4] = word;
      end else if (sz == SZ_BYTE) begin
        v = (word >> k) & 32'hFF;
        if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        exp_d = v;
      end else if (sz == SZ_HALF) begin
        v = (word >> k) & 32'hFFFF;
        if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        exp_d = v;
      end else begin
        exp_d = word;
      end
    end
    exp_lat = (w || exp_e) ? 1 : lat_of(d);

    @(negedge clk);
    vld[d] = 1'b1; we[d] = w; size[d] = sz; sgn[d] = sg; addr[d] = a; wdat[d] = wd;
    n = 0;
    while (!rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) chk("ready_timeout", 32'(rdy[d]), 32'd1);
    @(negedge clk);
    vld[d]  = 1'b0;
    wdat[d] = $urandom;
    n = 1;
    while (!rsp_vld[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("rsp_err", 32'(rsp_err[d]), 32'(exp_e));
    chk("rsp_rdata", rsp_dat[d], exp_d);
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_vld[d]), 32'd0);
  endtask

  // Back-to-back loads with req_valid held high.
  task automatic burst(input int d);
    int acc, rsps, last, bad_gap, bad_dat;
    acc = 0; rsps = 0; last = -1; bad_gap = 0; bad_dat = 0;
    @(negedge clk);
    vld[d] = 1'b1; we[d] = 1'b0; size[d] = SZ_WORD; sgn[d] = 1'b0; addr[d] = BASE;
    for (int c = 0; c < 40; c++) begin
      if (rsp_vld[d]) begin
        rsps++;
        if (rsp_dat[d] !== mdl[d][0]) bad_dat++;
      end
      if (rdy[d]) begin
        if (last >= 0 && c - last != lat_of(d) + 1) bad_gap++;
        last = c;
        acc++;
      end
      @(negedge clk);
    end
    vld[d] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_vld[d]) begin
        rsps++;
        if (rsp_dat[d] !== mdl[d][0]) bad_dat++;
      end
      @(negedge clk);
    end
    chk("burst_accepts", acc, (40 + lat_of(d)) / (lat_of(d) + 1));
    chk("burst_rsps", rsps, acc);
    chk("burst_gap", bad_gap, 0);
    chk("burst_data", bad_dat, 0);
  endtask

  task automatic reset_in_wait(input int d);
    int pulses;
    @(negedge clk);
    vld[d] = 1'b1; we[d] = 1'b0; size[d] = SZ_WORD; sgn[d] = 1'b0; addr[d] = BASE;
    @(negedge clk);
    vld[d] = 1'b0;
    rst[d] = 1'b1;
    pulses = int'(rsp_vld[d]);
    @(negedge clk);
    rst[d] = 1'b0;
    chk("rdy_after_rst", 32'(rdy[d]), 32'd1);
`ifdef DMEM_ERR_LOG_EN
    chk("sticky_cleared", 32'(sticky[d]), 32'd0);
`endif
    for (int c = 0; c < 8; c++) begin
      pulses += int'(rsp_vld[d]);
      @(negedge clk);
    end
    chk("aborted_rsp", pulses, 0);
    txn(d, 1'b0, SZ_WORD, 1'b0, BASE, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    rst = '1; vld = '0; we = '0; sgn = '0;
    for (int d = 0; d < NI; d++) begin
      size[d] = SZ_WORD; addr[d] = BASE; wdat[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = '0;
    for (int d = 0; d < NI; d++) begin
      chk("reset_ready", 32'(rdy[d]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_vld[d]), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_dat[d], 32'd0);
    end

    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < NW; i++) txn(d, 1'b1, SZ_WORD, 1'b0, BASE + 32'(4 * i), $urandom);

      txn(d, 1'b1, SZ_WORD, 1'b0, BASE, 32'hDEAD_BEEF);
      txn(d, 1'b0, SZ_WORD, 1'b0, BASE, 32'd0);
      txn(d, 1'b0, SZ_BYTE, 1'b1, BASE + 32'd3, 32'd0);
      txn(d, 1'b0, SZ_BYTE, 1'b0, BASE + 32'd3, 32'd0);
      txn(d, 1'b0, SZ_HALF, 1'b1, BASE, 32'd0);
      txn(d, 1'b0, SZ_HALF, 1'b0, BASE + 32'd2, 32'd0);
      txn(d, 1'b1, SZ_BYTE, 1'b0, BASE + 32'd1, 32'h0000_0012);
      txn(d, 1'b0, SZ_WORD, 1'b0, BASE, 32'd0);
      txn(d, 1'b1, SZ_HALF, 1'b0, BASE + 32'd2, 32'h0000_5678);
      txn(d, 1'b0, SZ_WORD, 1'b0, BASE, 32'd0);

      txn(d, 1'b0, SZ_WORD, 1'b0, BASE + 32'd2, 32'd0);
      txn(d, 1'b1, SZ_HALF, 1'b0, BASE + 32'd3, 32'hFFFF_FFFF);
      txn(d, 1'b0, SZ_WORD, 1'b0, 32'h1000_FFFC, 32'd0);
      txn(d, 1'b0, SZ_WORD, 1'b0, 32'h1001_1000, 32'd0);
      txn(d, 1'b1, 2'b11, 1'b0, BASE, 32'hFFFF_FFFF);
      txn(d, 1'b0, SZ_WORD, 1'b0, BASE, 32'd0);
`ifdef DMEM_ERR_LOG_EN
      chk("err_sticky", 32'(sticky[d]), 32'd1);
      chk("err_addr", eaddr[d], 32'h1001_0002);
`endif

      for (int t = 0; t < 60; t++) begin
        r = int'($urandom % 8);
        if (r == 0)      a = BASE + 32'd4096 + ($urandom % 64);
        else if (r == 1) a = BASE - 32'd1 - ($urandom % 64);
        else             a = BASE + ($urandom % 64);
        txn(d, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      end

      burst(d);
      if (lat_of(d) > 1) reset_in_wait(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised, handshaked data-memory controller that replaces the fixed single-cycle data memory and its external address subtraction in the single-cycle computer top level.
- Decodes CPU byte addresses against a configurable base address (default matches the MARS data segment).
- Performs byte, halfword and word loads and stores with sign or zero extension.
- Models a configurable read latency so that slower memories can be emulated.
- Flags misaligned and out-of-range accesses instead of silently wrapping.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address mapped to word 0 of storage.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, >= 2.
- READ_LAT, 1, cycles from load acceptance to rsp_valid; legal range 1..8.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, CPU presents a request.
- req_ready, out, 1, controller can accept a request this cycle.
- req_we, in, 1, 1 = store, 0 = load.
- req_size, in, 2, 00 byte, 01 half, 10 word; 11 is illegal and raises err.
- req_signed, in, 1, sign-extend loads (LB/LH); 0 = zero-extend (LBU/LHU); ignored for words and stores.
- req_addr, in, 32, CPU byte address (unmapped).
- req_wdata, in, 32, store data, right-aligned.
- rsp_valid, out, 1, one-cycle pulse that completes the accepted request.
- rsp_rdata, out, 32, extended load data; 0 for stores and on errors.
- rsp_err, out, 1, qualified by rsp_valid: misaligned, out of range, or illegal size.

Behaviour:
- Reset: FSM to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Storage contents are NOT reset.
- Handshake: a request is accepted when req_valid && req_ready. The controller captures addr, size, signed, we and wdata on acceptance. Request inputs are don't-care otherwise.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready=1. On accept, go to RESP for a store or any error, or to WAIT for a good load with READ_LAT>1. For a good load with READ_LAT==1, go directly to RESP.
  - WAIT: req_ready=0. The counter runs READ_LAT-1 cycles, then the FSM enters RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle, then IDLE.
- Throughput: one request per 2 cycles when READ_LAT=1. req_ready never asserts while a response is pending.
- Latency, counted from the accept edge: a store or error responds in 1 cycle; a load responds in READ_LAT cycles.
- Address: off = req_addr - BASE_ADDR, modulo 2^32. Out of range when off >= DEPTH_WORDS*4, which includes addresses below the base via wrap. Word index = off[log2(DEPTH_WORDS)+1:2].
- Alignment: half needs addr[0]==0; word needs addr[1:0]==0.
- Errors: any error gives rsp_err=1, rsp_rdata=0, and storage is unmodified.
- Stores:
  - Byte lanes use little-endian order: lane = addr[1:0].
  - SB writes wdata[7:0] into lane addr[1:0].
  - SH writes wdata[15:0] into lanes {addr[1],0}..+1.
  - SW writes all four lanes.
  - The write commits at the accept edge.
- Loads:
  - Data are read from storage at the accept edge and held through WAIT.
  - The selected lane(s) are extended per req_signed.
- A store followed by a load to the same word returns the new data, because the store commits before the next accept.
- Reset asserted in WAIT or RESP aborts the request: no rsp_valid is produced, and a store already committed stays committed.

Optional Feature:
DMEM_ERR_LOG_EN
- Defined: adds output err_sticky (1 bit) and output err_addr (32 bits).
  - On the first errored request since reset, err_sticky latches 1 and err_addr captures req_addr.
  - Later errors do not overwrite err_addr.
  - Both fields clear only on rst.
- Undefined: these ports and registers do not exist, and the behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum (IDLE, WAIT, RESP);
  - the default MARS base constant 32'h1001_0000.
- One sub-module, dmem_lane_fmt, is purely combinational:
  - store path: size + addr[1:0] + wdata to byte-enable[3:0] + replicated write word;
  - load path: raw word + size + addr[1:0] + signed to extended result;
  - misalignment detect.
- The top level holds the FSM, latency counter, range check and storage array.

Test Plan:
1. SW 32'hDEADBEEF to 0x1001_0000, then LW from the same address -> rsp_rdata=32'hDEADBEEF, rsp_err=0. The load rsp_valid arrives READ_LAT cycles after its accept; run with READ_LAT=1 and READ_LAT=4.
2. After test 1, LB 0x1001_0003 signed -> 32'hFFFFFFDE. LBU 0x1001_0003 -> 32'h000000DE. LH 0x1001_0000 signed -> 32'hFFFFBEEF. LHU 0x1001_0002 -> 32'h0000DEAD.
3. SB 8'h12 to 0x1001_0001, then LW 0x1001_0000 -> 32'hDEAD12EF. SH 16'h5678 to 0x1001_0002 -> word reads 32'h567812EF.
4. LW 0x1001_0002, SH 0x1001_0003, LW 0x1000_FFFC and LW 0x1001_1000 (DEPTH_WORDS=1024) -> each gives rsp_err=1 and rdata=0. Memory is unchanged. With DMEM_ERR_LOG_EN, err_addr=0x1001_0002 and err_sticky=1.
5. Handshake with READ_LAT=3: hold req_valid high continuously -> req_ready is low for 3 cycles after accept, exactly one rsp_valid pulse per request, and no accepts are lost or duplicated.
6. Assert rst during WAIT of a load -> no rsp_valid, req_ready=1 the cycle after reset releases, and previously stored data is still readable.
